mem_access: RTL and testbench

Memory-stage access controller for the 16-bit pipeline. It takes the EX/MEM load/store request, runs a req/ack transaction on the external data bus, stalls the upstream pipeline until the access completes, and presents the load data and gated write-back controls to the MEM/WB register. MEM/WB has no enable, so this block inserts bubbles (RegWrite2 forced low) while stalled.

---
 rtl/mem_access_if.sv | 27 ++
 rtl/mem_access.sv | 124 ++++++++++++
 tb/tb_mem_access.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// External data bus between the memory-stage access controller and memory.
interface mem_access_if;
    logic        BusReq;
    logic        BusWe;
    logic [15:0] BusAddr;
    logic [15:0] BusWData;
    logic        BusAck;
    logic [15:0] BusRData;

    modport master (
        output BusReq,
        output BusWe,
        output BusAddr,
        output BusWData,
        input  BusAck,
        input  BusRData
    );

    modport slave (
        input  BusReq,
        input  BusWe,
        input  BusAddr,
        input  BusWData,
        output BusAck,
        output BusRData
    );
endinterface

// File: rtl/mem_access.sv
// Memory-stage access controller: runs one req/ack bus transaction per
// load/store, stalls the upstream pipeline meanwhile and gates RegWrite
// towards MEM/WB so stalled cycles become bubbles.
module mem_access #(
    parameter int unsigned TIMEOUT    = 255,
    parameter logic [15:0] FAULT_DATA = 16'hFFFF
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [15:0] Addr,
    input  logic [15:0] WData,
    input  logic        RegWriteIn,
    output logic        RegWrite2,
    output logic [15:0] DataOut2,
    output logic        Stall,
    output logic        Fault,
    mem_access_if.master bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    // Counter value seen in the last ACCESS cycle before abort.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        busreq_q, busreq_d;
    logic        buswe_q, buswe_d;
    logic [15:0] busaddr_q, busaddr_d;
    logic [15:0] buswdata_q, buswdata_d;
    logic [15:0] dout_q, dout_d;
    logic        fault_q, fault_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req;

    // A store wins when both MemRead and MemWrite are set.
    assign req = MemRead | MemWrite;

    // State and bus registers; reset abandons any transaction in flight.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q    <= IDLE;
            busreq_q   <= 1'b0;
            buswe_q    <= 1'b0;
            busaddr_q  <= 16'h0000;
            buswdata_q <= 16'h0000;
            dout_q     <= 16'h0000;
            fault_q    <= 1'b0;
            cnt_q      <= 8'h00;
        end else begin
            state_q    <= state_d;
            busreq_q   <= busreq_d;
            buswe_q    <= buswe_d;
            busaddr_q  <= busaddr_d;
            buswdata_q <= buswdata_d;
            dout_q     <= dout_d;
            fault_q    <= fault_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next-state, bus launch/completion and pipeline stall/bubble control.
    always_comb begin
        state_d    = state_q;
        busreq_d   = busreq_q;
        buswe_d    = buswe_q;
        busaddr_d  = busaddr_q;
        buswdata_d = buswdata_q;
        dout_d     = dout_q;
        fault_d    = fault_q;
        cnt_d      = cnt_q;
        Stall      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    Stall      = 1'b1;
                    busaddr_d  = Addr;
                    buswdata_d = WData;
                    buswe_d    = MemWrite;
                    busreq_d   = 1'b1;
                    cnt_d      = 8'h00;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                Stall = 1'b1;
                // A read is any transaction launched with BusWe low.
                if (bus.BusAck) begin
                    if (!buswe_q) dout_d = bus.BusRData;
                    busreq_d = 1'b0;
                    buswe_d  = 1'b0;
                    state_d  = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    if (!buswe_q) dout_d = FAULT_DATA;
                    busreq_d = 1'b0;
                    buswe_d  = 1'b0;
                    fault_d  = 1'b1;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + 8'h01;
                end
            end
            DONE: begin
                fault_d = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        RegWrite2 = RegWriteIn & ~Stall;
    end

    assign bus.BusReq   = busreq_q;
    assign bus.BusWe    = buswe_q;
    assign bus.BusAddr  = busaddr_q;
    assign bus.BusWData = buswdata_q;
    assign DataOut2     = dout_q;
    assign Fault        = fault_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: table of directed transactions, reset corner cases
// and randomized transactions against a transaction-level model.
module tb_mem_access;

    localparam int          TO    = 4;
    localparam logic [15:0] FDATA = 16'hFFFF;

    logic        Clk;
    logic        Rst;
    logic        MemRead;
    logic        MemWrite;
    logic [15:0] Addr;
    logic [15:0] WData;
    logic        RegWriteIn;
    logic        RegWrite2;
    logic [15:0] DataOut2;
    logic        Stall;
    logic        Fault;

    mem_access_if bus ();

    mem_access #(.TIMEOUT(TO), .FAULT_DATA(FDATA)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Addr       (Addr),
        .WData      (WData),
        .RegWriteIn (RegWriteIn),
        .RegWrite2  (RegWrite2),
        .DataOut2   (DataOut2),
        .Stall      (Stall),
        .Fault      (Fault),
        .bus        (bus.master)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        mr;
        logic        mw;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        rwi;
        int          ack_k;     // ACCESS cycle carrying the ack; > TO means never
        logic [15:0] rdata;
        logic [15:0] exp_dout;  // DataOut2 after the transaction
    } txn_t;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_dout;
    txn_t        tbl [7];
    txn_t        t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Starts and ends just after a rising edge with the DUT in IDLE.
    // The trailing idle cycle is an ALU op with RegWriteIn=1 and a stray ack.
    task automatic run_txn(input txn_t x);
        bit tout;
        bit is_rd;
        int n;
        is_rd = x.mr && !x.mw;
        tout  = !(x.ack_k >= 1 && x.ack_k <= TO);
        n     = tout ? TO : x.ack_k;
        MemRead = x.mr; MemWrite = x.mw; Addr = x.addr; WData = x.wdata;
        RegWriteIn = x.rwi; bus.BusAck = 1'b0;
        @(negedge Clk);
        chk("idle_stall", Stall, 1'b1);
        chk("idle_rw2", RegWrite2, 1'b0);
        chk("idle_busreq", bus.BusReq, 1'b0);
        chk("idle_dout", DataOut2, exp_dout);
        for (int c = 1; c <= n; c++) begin
            @(posedge Clk); #1;
            bus.BusAck   = (c == x.ack_k);
            bus.BusRData = (c == x.ack_k) ? x.rdata : 16'($urandom);
            @(negedge Clk);
            chk("acc_stall", Stall, 1'b1);
            chk("acc_rw2", RegWrite2, 1'b0);
            chk("acc_busreq", bus.BusReq, 1'b1);
            chk("acc_buswe", bus.BusWe, x.mw);
            chk("acc_busaddr", bus.BusAddr, x.addr);
            chk("acc_buswdata", bus.BusWData, x.wdata);
            chk("acc_fault", Fault, 1'b0);
        end
        @(posedge Clk); #1;
        bus.BusAck = 1'b0;
        if (is_rd) exp_dout = tout ? FDATA : x.rdata;
        @(negedge Clk);
        chk("done_stall", Stall, 1'b0);
        chk("done_rw2", RegWrite2, x.rwi);
        chk("done_fault", Fault, tout);
        chk("done_busreq", bus.BusReq, 1'b0);
        chk("done_dout", DataOut2, exp_dout);
        if (!tout) chk("done_buswe", bus.BusWe, 1'b0);
        @(posedge Clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0; RegWriteIn = 1'b1;
        bus.BusAck = 1'b1; bus.BusRData = 16'($urandom);
        @(negedge Clk);
        chk("alu_stall", Stall, 1'b0);
        chk("alu_rw2", RegWrite2, 1'b1);
        chk("alu_fault", Fault, 1'b0);
        chk("alu_busreq", bus.BusReq, 1'b0);
        @(posedge Clk); #1;
        bus.BusAck = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 1'b1, 1,      16'hBEEF, 16'hBEEF};
        tbl[1] = '{1'b0, 1'b1, 16'h0012, 16'h1234, 1'b0, 3,      16'h0000, 16'hBEEF};
        tbl[2] = '{1'b1, 1'b0, 16'h0077, 16'h0000, 1'b1, TO + 1, 16'h0000, 16'hFFFF};
        tbl[3] = '{1'b1, 1'b0, 16'h0100, 16'h0000, 1'b1, 1,      16'h1111, 16'h1111};
        tbl[4] = '{1'b0, 1'b1, 16'h0101, 16'hCAFE, 1'b0, 1,      16'h0000, 16'h1111};
        tbl[5] = '{1'b1, 1'b1, 16'h0200, 16'h5678, 1'b1, 2,      16'h9999, 16'h1111};
        tbl[6] = '{1'b1, 1'b0, 16'h0300, 16'h0000, 1'b1, TO,     16'h2222, 16'h2222};

        Rst = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Addr = 16'h0; WData = 16'h0;
        RegWriteIn = 1'b0; bus.BusAck = 1'b0; bus.BusRData = 16'h0;
        exp_dout = 16'h0000;
        #13;
        chk("rst_busreq", bus.BusReq, 1'b0);
        chk("rst_buswe", bus.BusWe, 1'b0);
        chk("rst_fault", Fault, 1'b0);
        chk("rst_busaddr", bus.BusAddr, 16'h0000);
        chk("rst_buswdata", bus.BusWData, 16'h0000);
        chk("rst_dout", DataOut2, 16'h0000);
        chk("rst_stall", Stall, 1'b0);
        @(negedge Clk); Rst = 1'b1;
        @(posedge Clk); #1;

        for (int i = 0; i < 7; i++) begin
            run_txn(tbl[i]);
            chk("tbl_dout", DataOut2, tbl[i].exp_dout);
        end

        // Reset in the middle of a load abandons it; a later ack is ignored.
        MemRead = 1'b1; MemWrite = 1'b0; Addr = 16'h0555; RegWriteIn = 1'b1;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        @(negedge Clk);
        chk("mid_busreq_before", bus.BusReq, 1'b1);
        #2;
        MemRead = 1'b0; RegWriteIn = 1'b0;
        Rst = 1'b0;
        #1;
        chk("mid_busreq", bus.BusReq, 1'b0);
        chk("mid_dout", DataOut2, 16'h0000);
        chk("mid_stall", Stall, 1'b0);
        exp_dout = 16'h0000;
        @(negedge Clk); Rst = 1'b1;
        @(posedge Clk); #1;
        bus.BusAck = 1'b1; bus.BusRData = 16'hA5A5;
        @(negedge Clk);
        chk("post_rst_stall", Stall, 1'b0);
        @(posedge Clk); #1;
        bus.BusAck = 1'b0;
        @(negedge Clk);
        chk("post_rst_busreq", bus.BusReq, 1'b0);
        chk("post_rst_dout", DataOut2, 16'h0000);
        @(posedge Clk); #1;

        for (int i = 0; i < 40; i++) begin
            int kind;
            kind     = $urandom_range(0, 2);
            t.mr     = (kind != 1);
            t.mw     = (kind != 0);
            t.addr   = 16'($urandom);
            t.wdata  = 16'($urandom);
            t.rwi    = 1'($urandom);
            t.ack_k  = $urandom_range(1, TO + 1);
            t.rdata  = 16'($urandom);
            t.exp_dout = 16'h0;
            run_txn(t);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
